// File: rtl/mem_if.sv
// Request/response bundle between the memory-address mux (master) and the
// word-addressed memory responder (slave).
interface mem_if;
  logic        req;
  logic        we;
  logic        IorD;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic        tag;

  modport master (
    output req, we, IorD, addr, wdata,
    input  rdata, ready, busy, err, tag
  );

  modport slave (
    input  req, we, IorD, addr, wdata,
    output rdata, ready, busy, err, tag
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port 32-bit word memory with fixed access latency, misalignment and
// range checking, and a one-cycle completion strobe.
//
// state | meaning
// IDLE  | waiting for req; accepts on the next rising edge
// WAIT  | request latched, latency counter running down to zero
// RESP  | ready high for one cycle; a new request may be accepted as it ends
module mem_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  mem_if.slave   bus
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        iord_q, iord_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tag_q, tag_d;

  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] word_idx;
  logic        acc_err;
  logic        accept;
  logic        complete;
  logic        mem_we;

  assign word_idx = addr_q[AW+1:2];
  assign acc_err  = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
  assign mem_we   = complete && we_q && !acc_err;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    iord_d   = iord_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tag_d    = tag_q;
    accept   = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: accept = bus.req;
      WAIT: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        accept  = bus.req;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = WAIT;
      cnt_d   = LAT_LOAD;
      we_d    = bus.we;
      iord_d  = bus.IorD;
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
    end

    if (complete) begin
      err_d   = acc_err;
      tag_d   = iord_q;
      rdata_d = (acc_err || we_q) ? 32'd0 : mem_q[word_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      iord_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      iord_q  <= iord_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
    end
  end

  // Storage keeps its contents across reset; an aborted access never reaches here.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= wdata_q;
    end
  end

  assign bus.ready = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.tag   = tag_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 and a LATENCY=1 instance,
// each with its own reference memory and expected-response queue.
module tb_mem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_if bus_a();
  mem_if bus_b();

  mem_responder #(.AW(8), .LATENCY(LAT_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mem_responder #(.AW(8), .LATENCY(LAT_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tag;
    int          ready_edge;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  exp_t        ea, eb;
  logic [31:0] model_a [int];
  logic [31:0] model_b [int];
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference behaviour for one accepted access (AW=8: 256 words).
  function automatic exp_t model_access(input bit sel_b, input logic we, input logic iord,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input int ready_edge);
    exp_t e;
    int   idx;
    idx          = int'(addr[9:2]);
    e.err        = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
    e.tag        = iord;
    e.ready_edge = ready_edge;
    e.rdata      = 32'd0;
    if (!e.err) begin
      if (we) begin
        if (sel_b) model_b[idx] = wdata;
        else       model_a[idx] = wdata;
      end else begin
        e.rdata = sel_b ? model_b[idx] : model_a[idx];
      end
    end
    return e;
  endfunction

  task automatic push(input bit sel_b, input exp_t e);
    if (sel_b) sb_b.push_back(e);
    else       sb_a.push_back(e);
  endtask

  task automatic drive(input bit sel_b, input logic req, input logic we, input logic iord,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel_b) begin
      bus_b.req = req; bus_b.we = we; bus_b.IorD = iord; bus_b.addr = addr; bus_b.wdata = wdata;
    end else begin
      bus_a.req = req; bus_a.we = we; bus_a.IorD = iord; bus_a.addr = addr; bus_a.wdata = wdata;
    end
  endtask

  task automatic wait_idle(input bit sel_b, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!(sel_b ? bus_b.busy : bus_a.busy)) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_timeout: busy still 1 after 40 cycles, required 0", name);
    end
  endtask

  // Single access from idle: accepted on the next edge, then wait until idle again.
  task automatic send(input bit sel_b, input logic we, input logic iord,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int lat;
    lat = sel_b ? LAT_B : LAT_A;
    drive(sel_b, 1'b1, we, iord, addr, wdata);
    @(posedge clk); #1;
    push(sel_b, model_access(sel_b, we, iord, addr, wdata, edge_n + lat));
    drive(sel_b, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_idle(sel_b, "send");
  endtask

  always @(negedge clk) begin
    if (bus_a.ready) begin
      n_cmp++;
      if (sb_a.size() == 0) begin
        n_bad++;
        $display("FAIL mon_a_spurious: ready=1 at edge %0d, required no response outstanding", edge_n);
      end else begin
        ea = sb_a.pop_front();
        if (bus_a.rdata !== ea.rdata || bus_a.err !== ea.err || bus_a.tag !== ea.tag ||
            edge_n !== ea.ready_edge) begin
          n_bad++;
          $display("FAIL mon_a_resp: got rdata=%h err=%b tag=%b edge=%0d, want rdata=%h err=%b tag=%b edge=%0d",
                   bus_a.rdata, bus_a.err, bus_a.tag, edge_n, ea.rdata, ea.err, ea.tag, ea.ready_edge);
        end
      end
    end
    if (bus_b.ready) begin
      n_cmp++;
      if (sb_b.size() == 0) begin
        n_bad++;
        $display("FAIL mon_b_spurious: ready=1 at edge %0d, required no response outstanding", edge_n);
      end else begin
        eb = sb_b.pop_front();
        if (bus_b.rdata !== eb.rdata || bus_b.err !== eb.err || bus_b.tag !== eb.tag ||
            edge_n !== eb.ready_edge) begin
          n_bad++;
          $display("FAIL mon_b_resp: got rdata=%h err=%b tag=%b edge=%0d, want rdata=%h err=%b tag=%b edge=%0d",
                   bus_b.rdata, bus_b.err, bus_b.tag, edge_n, eb.rdata, eb.err, eb.tag, eb.ready_edge);
        end
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus_a.ready, bus_a.busy, bus_a.err, bus_a.tag, bus_a.rdata} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_a: got ready=%b busy=%b err=%b tag=%b rdata=%h, required all 0",
               bus_a.ready, bus_a.busy, bus_a.err, bus_a.tag, bus_a.rdata);
    end
    n_cmp++;
    if ({bus_b.ready, bus_b.busy, bus_b.err, bus_b.tag, bus_b.rdata} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_b: got ready=%b busy=%b err=%b tag=%b rdata=%h, required all 0",
               bus_b.ready, bus_b.busy, bus_b.err, bus_b.tag, bus_b.rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_a.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b with req=0, required 0", bus_a.busy);
    end
  endtask

  task automatic test_write_read();
    send(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    send(1'b0, 1'b0, 1'b0, 32'h10, 32'd0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus_a.rdata !== 32'hDEADBEEF || bus_a.tag !== 1'b0 || bus_a.err !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_after_resp: got rdata=%h tag=%b err=%b, required rdata=deadbeef tag=0 err=0",
               bus_a.rdata, bus_a.tag, bus_a.err);
    end
  endtask

  task automatic test_misaligned();
    send(1'b0, 1'b1, 1'b1, 32'h13, 32'h12345678);
    send(1'b0, 1'b0, 1'b1, 32'h10, 32'd0);
  endtask

  task automatic test_out_of_range();
    send(1'b0, 1'b0, 1'b1, 32'h400, 32'd0);
    send(1'b0, 1'b1, 1'b0, 32'h3FC, 32'hCAFEF00D);
    send(1'b0, 1'b0, 1'b0, 32'h3FC, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    send(1'b0, 1'b1, 1'b0, 32'h104, 32'h55550001);
    for (int i = 0; i <= LAT_A + 1; i++) begin
      a = 32'h100 + 32'(4 * i);
      drive(1'b0, 1'b1, 1'b1, i[0], a, 32'hA0000000 + 32'(i));
      @(posedge clk); #1;
      if (i == 0 || i == LAT_A + 1) begin
        push(1'b0, model_access(1'b0, 1'b1, i[0], a, 32'hA0000000 + 32'(i), edge_n + LAT_A));
      end
      if (i == LAT_A + 1) begin
        n_cmp++;
        if (bus_a.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_busy: busy=%b right after re-acceptance, required 1", bus_a.busy);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_idle(1'b0, "b2b");
    send(1'b0, 1'b0, 1'b0, 32'h104, 32'd0);
    send(1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
    send(1'b0, 1'b0, 1'b0, 32'h100 + 32'(4 * (LAT_A + 1)), 32'd0);
  endtask

  task automatic test_reset_mid_op();
    send(1'b0, 1'b1, 1'b0, 32'h20, 32'h11112222);
    send(1'b0, 1'b0, 1'b1, 32'h20, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h55AA55AA);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (bus_a.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre_busy: busy=%b in WAIT, required 1", bus_a.busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.ready, bus_a.busy, bus_a.err, bus_a.tag, bus_a.rdata} !== 36'd0) begin
      n_bad++;
      $display("FAIL abort_reset: got ready=%b busy=%b err=%b tag=%b rdata=%h, required all 0",
               bus_a.ready, bus_a.busy, bus_a.err, bus_a.tag, bus_a.rdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(1'b0, 1'b0, 1'b0, 32'h20, 32'd0);
  endtask

  task automatic test_latency1();
    send(1'b1, 1'b1, 1'b0, 32'h40, 32'h0BADF00D);
    send(1'b1, 1'b0, 1'b1, 32'h40, 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, i[1], 32'h40, 32'd0);
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        push(1'b1, model_access(1'b1, 1'b0, i[1], 32'h40, 32'd0, edge_n + LAT_B));
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_idle(1'b1, "lat1");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_op();
    test_latency1();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: outstanding a=%0d b=%0d, required 0 and 0", sb_a.size(), sb_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
